// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ready bus between the fetch stage and imem.
// The fetch side holds req and addr steady until the memory answers with rdy.
interface fetch_stage_if;
  logic        req;
  logic [15:0] addr;
  logic        rdy;
  logic [15:0] data;

  modport master (output req, output addr, input rdy, input data);
  modport slave  (input req, input addr, output rdy, output data);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: issues imem requests at the PC, owns the IF/ID
// register, and handles hazard stalls, branch flushes and HLT.
module fetch_stage #(
  parameter logic [15:0] NOP_INSTR = 16'h0000,
  parameter logic [3:0]  HALT_OP   = 4'hF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        pc_addr,
  output logic               pc_advance,
  input  logic               stall,
  input  logic               flush,
  fetch_stage_if.master      imem,
  output logic [15:0]        if_id_instr,
  output logic [15:0]        if_id_pc_plus2,
  output logic               if_id_valid,
  output logic               halted,
  output logic               fetch_busy
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    HALT
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        kill;
  logic        next_kill;
  logic [15:0] req_addr;
  logic [15:0] buf_instr;
  logic [15:0] buf_pc_plus2;

  logic        accept;
  logic        load_buf;
  logic [15:0] accept_instr;
  logic [15:0] accept_pc_plus2;

  // kill marks a request whose answer must be thrown away because a flush
  // arrived before the memory responded; the bus is never aborted mid-access.
  always_comb begin
    next_state      = state;
    next_kill       = kill;
    imem.req        = 1'b0;
    imem.addr       = 16'h0000;
    pc_advance      = 1'b0;
    accept          = 1'b0;
    load_buf        = 1'b0;
    accept_instr    = buf_instr;
    accept_pc_plus2 = buf_pc_plus2;

    case (state)
      IDLE: begin
        next_state = REQ;
      end

      REQ: begin
        imem.req  = 1'b1;
        imem.addr = kill ? req_addr : pc_addr;
        if (imem.rdy) begin
          if (kill) begin
            next_kill = 1'b0;
          end else if (flush) begin
            next_state = REQ;
          end else if (stall) begin
            load_buf   = 1'b1;
            next_state = HOLD;
          end else begin
            accept          = 1'b1;
            accept_instr    = imem.data;
            accept_pc_plus2 = pc_addr + 16'd2;
          end
        end else if (flush) begin
          next_kill = 1'b1;
        end
      end

      HOLD: begin
        if (flush) begin
          next_state = REQ;
        end else if (!stall) begin
          accept = 1'b1;
        end
      end

      HALT: begin
        if (flush) begin
          next_state = REQ;
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase

    if (accept) begin
      pc_advance = 1'b1;
      next_state = (accept_instr[15:12] == HALT_OP) ? HALT : REQ;
    end
  end

  assign halted     = (state == HALT);
  assign fetch_busy = imem.req & ~imem.rdy;

  // req_addr shadows the address of the access in flight so that a killed
  // request keeps presenting its original address after the PC is redirected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      kill         <= 1'b0;
      req_addr     <= 16'h0000;
      buf_instr    <= NOP_INSTR;
      buf_pc_plus2 <= 16'h0000;
    end else begin
      state <= next_state;
      kill  <= next_kill;
      if (state == REQ && !kill) begin
        req_addr <= pc_addr;
      end
      if (load_buf) begin
        buf_instr    <= imem.data;
        buf_pc_plus2 <= pc_addr + 16'd2;
      end
    end
  end

  // IF/ID: flush beats everything, then a newly accepted instruction, then
  // a stall hold; any other cycle inserts a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_instr    <= NOP_INSTR;
      if_id_pc_plus2 <= 16'h0000;
      if_id_valid    <= 1'b0;
    end else if (flush) begin
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (accept) begin
      if_id_instr    <= accept_instr;
      if_id_pc_plus2 <= accept_pc_plus2;
      if_id_valid    <= 1'b1;
    end else if (!stall) begin
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: plays PC register, hazard unit and a random-latency
// instruction memory, and checks IF/ID against a program-order reference.
module tb_fetch_stage;

  localparam logic [15:0] NOP        = 16'h0000;
  localparam int          IDLE_LIMIT = 60;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_addr;
  logic        pc_advance;
  logic        stall;
  logic        flush;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc_plus2;
  logic        if_id_valid;
  logic        halted;
  logic        fetch_busy;

  fetch_stage_if imem_bus ();

  fetch_stage #(
    .NOP_INSTR (16'h0000),
    .HALT_OP   (4'hF)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_addr        (pc_addr),
    .pc_advance     (pc_advance),
    .stall          (stall),
    .flush          (flush),
    .imem           (imem_bus),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus2 (if_id_pc_plus2),
    .if_id_valid    (if_id_valid),
    .halted         (halted),
    .fetch_busy     (fetch_busy)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  logic [15:0] mem [0:255];

  // reference state: what IF/ID and halted must hold after the next edge
  logic        exp_valid;
  logic [15:0] exp_instr;
  logic [15:0] exp_pc2;
  bit          exp_pc2_check;
  bit          halt_flag;
  bit          flush_q;
  bit          adv_q;
  logic [15:0] flush_target;
  int          idle_cycles;

  // memory and stimulus knobs
  bit          outstanding;
  int          lat;
  int          wait_cnt;
  bit          prev_wait;
  logic [15:0] prev_addr;
  int          max_lat;
  int          stall_pct;
  int          flush_pct;
  bit          tied_mode;
  bit          force_flush;
  logic [15:0] force_target;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return mem[a[8:1]];
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_values();
    checkOutput("rst_imem_req", imem_bus.req, 0);
    checkOutput("rst_imem_addr", imem_bus.addr, 16'h0000);
    checkOutput("rst_pc_advance", pc_advance, 0);
    checkOutput("rst_valid", if_id_valid, 0);
    checkOutput("rst_instr", if_id_instr, NOP);
    checkOutput("rst_pc_plus2", if_id_pc_plus2, 16'h0000);
    checkOutput("rst_halted", halted, 0);
    checkOutput("rst_fetch_busy", fetch_busy, 0);
  endtask

  task automatic model_reset();
    exp_valid     = 1'b0;
    exp_instr     = NOP;
    exp_pc2       = 16'h0000;
    exp_pc2_check = 1'b0;
    halt_flag     = 1'b0;
    flush_q       = 1'b0;
    adv_q         = 1'b0;
    outstanding   = 1'b0;
    prev_wait     = 1'b0;
    idle_cycles   = 0;
  endtask

  // random hazard inputs plus a memory that answers each request after 0..max_lat cycles
  task automatic applyStimulus();
    stall = ($urandom_range(0, 99) < stall_pct);
    flush = ($urandom_range(0, 99) < flush_pct);
    if (flush) flush_target = 16'($urandom) & 16'hFFFE;
    if (force_flush) begin
      flush        = 1'b1;
      flush_target = force_target;
    end
    if (prev_wait) begin
      checkOutput("req_held", imem_bus.req, 1);
      checkOutput("addr_stable", imem_bus.addr, prev_addr);
    end
    if (imem_bus.req) begin
      if (!outstanding) begin
        outstanding = 1'b1;
        wait_cnt    = 0;
        lat         = $urandom_range(0, max_lat);
        checkOutput("new_req_addr", imem_bus.addr, pc_addr);
      end
      imem_bus.rdy  = (wait_cnt == lat);
      imem_bus.data = imem_bus.rdy ? mem_word(imem_bus.addr) : 16'($urandom);
    end else begin
      outstanding   = 1'b0;
      imem_bus.rdy  = 1'b0;
      imem_bus.data = 16'($urandom);
    end
  endtask

  task automatic run_cycle(input bit do_rst);
    logic [15:0] w;
    @(posedge clk);
    #1;
    checkOutput("if_id_valid", if_id_valid, exp_valid);
    checkOutput("if_id_instr", if_id_instr, exp_instr);
    if (exp_pc2_check) checkOutput("if_id_pc_plus2", if_id_pc_plus2, exp_pc2);
    checkOutput("halted", halted, halt_flag);
    if (flush_q) pc_addr = flush_target;
    else if (adv_q) pc_addr = pc_addr + 16'd2;
    #1;
    applyStimulus();

    if (do_rst) begin
      #1 rst = 1'b1;
      #1;
      check_reset_values();
      stall        = 1'b0;
      flush        = 1'b0;
      imem_bus.rdy = 1'b0;
      model_reset();
      @(posedge clk);
      #2 rst = 1'b0;
      return;
    end

    @(negedge clk);
    checkOutput("fetch_busy", fetch_busy, imem_bus.req & ~imem_bus.rdy);
    checkOutput("adv_with_flush", pc_advance & flush, 0);
    if (halt_flag) begin
      checkOutput("halt_no_req", imem_bus.req, 0);
      checkOutput("halt_no_adv", pc_advance, 0);
    end
    if (tied_mode) checkOutput("adv_tied", pc_advance, imem_bus.req & ~flush);

    if (halt_flag || pc_advance) idle_cycles = 0;
    else idle_cycles++;
    checkOutput("progress", idle_cycles > IDLE_LIMIT, 0);
    if (idle_cycles > IDLE_LIMIT) idle_cycles = 0;

    // program-order reference: an accepted instruction is the word at the PC
    if (flush) begin
      exp_valid     = 1'b0;
      exp_instr     = NOP;
      exp_pc2_check = 1'b0;
      halt_flag     = 1'b0;
    end else if (pc_advance) begin
      w             = mem_word(pc_addr);
      exp_valid     = 1'b1;
      exp_instr     = w;
      exp_pc2       = pc_addr + 16'd2;
      exp_pc2_check = 1'b1;
      if (w[15:12] == 4'hF) halt_flag = 1'b1;
    end else if (!stall) begin
      exp_valid     = 1'b0;
      exp_instr     = NOP;
      exp_pc2_check = 1'b0;
    end

    flush_q   = flush;
    adv_q     = pc_advance;
    prev_wait = imem_bus.req & ~imem_bus.rdy;
    prev_addr = imem_bus.addr;
    if (imem_bus.req) begin
      if (imem_bus.rdy) outstanding = 1'b0;
      else wait_cnt++;
    end
  endtask

  initial begin
    logic [15:0] w;
    rst           = 1'b1;
    stall         = 1'b0;
    flush         = 1'b0;
    pc_addr       = 16'h0000;
    imem_bus.rdy  = 1'b0;
    imem_bus.data = 16'h0000;
    flush_target  = 16'h0000;
    force_flush   = 1'b0;
    force_target  = 16'h0000;
    tied_mode     = 1'b0;
    max_lat       = 0;
    stall_pct     = 0;
    flush_pct     = 0;
    lat           = 0;
    wait_cnt      = 0;
    prev_addr     = 16'h0000;
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      if ((i < 8 || i > 250) && w[15:12] == 4'hF) w[15:12] = 4'h1;
      mem[i] = w;
    end
    mem[0] = 16'h1111;
    mem[1] = 16'h2222;
    mem[2] = 16'h3333;
    model_reset();

    #3;
    check_reset_values();
    @(posedge clk);
    #2 rst = 1'b0;

    // rdy tied high from PC 0000: one instruction per clock
    tied_mode = 1'b1;
    repeat (4) run_cycle(1'b0);

    // branch to FFFC, then stream across the 16-bit PC wrap
    force_flush  = 1'b1;
    force_target = 16'hFFFC;
    run_cycle(1'b0);
    force_flush = 1'b0;
    repeat (4) run_cycle(1'b0);

    // randomized latency, stalls, flushes, halts and mid-request resets
    tied_mode = 1'b0;
    max_lat   = 3;
    stall_pct = 25;
    flush_pct = 8;
    for (int i = 0; i < 1500; i++) begin
      run_cycle(i == 400 || i == 1000);
    end
    stall_pct = 0;
    flush_pct = 0;
    run_cycle(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit at %0t", $time);
    $fatal(1, "[TB] timeout");
  end

endmodule
